id_ex_stage: RTL



---
 rtl/rv32i_types.sv | 37 +++
 rtl/imm_gen.sv | 31 +++
 rtl/id_ex_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I opcodes, field positions and ID/EX register layout
package rv32i_types;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011
    } opcode_e;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } id_ex_regs_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction, sign-extended from instr[31]
module imm_gen
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opcode;

    assign opcode = instr[OPC_MSB:OPC_LSB];

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand fetch and load-use bubble insertion
module id_ex_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_instr,
    output logic [4:0]  rf_src_a,
    output logic [4:0]  rf_src_b,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        id_hold,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_instr,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm
);

    logic [6:0]  opcode;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        ex_is_load;
    logic        load_use;
    logic [31:0] id_imm;
    id_ex_regs_t ex_q;
    id_ex_regs_t ex_d;

    assign opcode = id_instr[OPC_MSB:OPC_LSB];

    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
            default:                     uses_rs1 = 1'b1;
        endcase
        case (opcode)
            OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
        case (opcode)
            OPC_BRANCH, OPC_STORE: writes_rd = 1'b0;
            default:               writes_rd = 1'b1;
        endcase
    end

    // Unused sources read x0 so they can never match a forwarding or hazard compare.
    assign rf_src_a = uses_rs1 ? id_instr[RS1_MSB:RS1_LSB] : 5'd0;
    assign rf_src_b = uses_rs2 ? id_instr[RS2_MSB:RS2_LSB] : 5'd0;

    imm_gen u_imm_gen (
        .instr (id_instr),
        .imm   (id_imm)
    );

    assign ex_is_load = (ex_q.instr[OPC_MSB:OPC_LSB] == OPC_LOAD);
    assign load_use   = ex_q.valid && ex_is_load && (ex_q.rd != 5'd0) && id_valid &&
                        ((uses_rs1 && (rf_src_a == ex_q.rd)) ||
                         (uses_rs2 && (rf_src_b == ex_q.rd)));
    assign id_hold    = mem_stall || (load_use && !flush);

    always_comb begin
        ex_d = ex_q;
        if (mem_stall) begin
            ex_d = ex_q;
        end else if (flush || load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = id_valid;
            ex_d.pc       = id_pc;
            ex_d.instr    = id_instr;
            ex_d.rs1      = rf_src_a;
            ex_d.rs2      = rf_src_b;
            ex_d.rd       = writes_rd ? id_instr[RD_MSB:RD_LSB] : 5'd0;
            ex_d.rs1_data = reg_a;
            ex_d.rs2_data = reg_b;
            ex_d.imm      = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_instr    = ex_q.instr;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;

endmodule
